// File: rtl/sc_statemachinegame_if.sv
// Control/status bundle between the frog game sequencer and the rest of the board.
// The slave side is the game sequencer; the master side drives buttons and collision/goal/tick inputs.
interface sc_statemachinegame_if;
  logic       SC_STATEMACHINEGAME_startButton_InLow;
  logic       SC_STATEMACHINEGAME_tick_InHigh;
  logic       SC_STATEMACHINEGAME_collision_InHigh;
  logic       SC_STATEMACHINEGAME_goal_InHigh;
  logic       SC_STATEMACHINEGAME_pointClear_OutLow;
  logic       SC_STATEMACHINEGAME_playing_OutHigh;
  logic       SC_STATEMACHINEGAME_carShift_OutHigh;
  logic [1:0] SC_STATEMACHINEGAME_lives_Out;
  logic [2:0] SC_STATEMACHINEGAME_level_Out;
  logic       SC_STATEMACHINEGAME_gameOver_OutHigh;
  logic       SC_STATEMACHINEGAME_win_OutHigh;

  modport master (
    output SC_STATEMACHINEGAME_startButton_InLow, SC_STATEMACHINEGAME_tick_InHigh,
           SC_STATEMACHINEGAME_collision_InHigh, SC_STATEMACHINEGAME_goal_InHigh,
    input  SC_STATEMACHINEGAME_pointClear_OutLow, SC_STATEMACHINEGAME_playing_OutHigh,
           SC_STATEMACHINEGAME_carShift_OutHigh, SC_STATEMACHINEGAME_lives_Out,
           SC_STATEMACHINEGAME_level_Out, SC_STATEMACHINEGAME_gameOver_OutHigh,
           SC_STATEMACHINEGAME_win_OutHigh
  );

  modport slave (
    input  SC_STATEMACHINEGAME_startButton_InLow, SC_STATEMACHINEGAME_tick_InHigh,
           SC_STATEMACHINEGAME_collision_InHigh, SC_STATEMACHINEGAME_goal_InHigh,
    output SC_STATEMACHINEGAME_pointClear_OutLow, SC_STATEMACHINEGAME_playing_OutHigh,
           SC_STATEMACHINEGAME_carShift_OutHigh, SC_STATEMACHINEGAME_lives_Out,
           SC_STATEMACHINEGAME_level_Out, SC_STATEMACHINEGAME_gameOver_OutHigh,
           SC_STATEMACHINEGAME_win_OutHigh
  );
endinterface

// File: rtl/sc_statemachinegame.sv
// Frog game sequencer: start/arm, play with level-dependent car shift rate,
// hit/freeze handling with lives, level-up, game-over and win.
module sc_statemachinegame #(
  parameter int LIVES_INIT  = 3,
  parameter int LEVEL_MAX   = 7,
  parameter int BASE_PERIOD = 8,
  parameter int HOLD_TICKS  = 4
) (
  input logic                  SC_STATEMACHINEGAME_CLOCK_50,
  input logic                  SC_STATEMACHINEGAME_RESET_InHigh,
  sc_statemachinegame_if.slave gameBus
);
  localparam int SHIFT_W = $clog2(BASE_PERIOD + 1);
  localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);

  typedef enum logic [2:0] {
    IDLE, ARM, PLAY, HIT, HOLD, LEVELUP, GAMEOVER, WIN
  } gameState;

  gameState           stateReg, stateNext;
  logic [1:0]         livesReg, livesNext;
  logic [2:0]         levelReg, levelNext;
  logic [SHIFT_W-1:0] shiftCountReg, shiftCountNext;
  logic [HOLD_W-1:0]  holdCountReg, holdCountNext;
  logic               carShiftReg, carShiftNext;
  logic               pointClear;
  logic [31:0]        shiftPeriod;
  logic               startPressed, tickPulse, collision, goal;

  assign startPressed = ~gameBus.SC_STATEMACHINEGAME_startButton_InLow;
  assign tickPulse    = gameBus.SC_STATEMACHINEGAME_tick_InHigh;
  assign collision    = gameBus.SC_STATEMACHINEGAME_collision_InHigh;
  assign goal         = gameBus.SC_STATEMACHINEGAME_goal_InHigh;

  // Cars speed up one tick per level, but never faster than one shift per tick.
  always_comb begin
    if (32'(BASE_PERIOD) > 32'(levelReg)) shiftPeriod = 32'(BASE_PERIOD) - 32'(levelReg);
    else                                  shiftPeriod = 32'd1;
  end

  always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50) begin
    if (SC_STATEMACHINEGAME_RESET_InHigh) begin
      stateReg      <= IDLE;
      livesReg      <= 2'(LIVES_INIT);
      levelReg      <= 3'd0;
      shiftCountReg <= '0;
      holdCountReg  <= '0;
      carShiftReg   <= 1'b0;
    end else begin
      stateReg      <= stateNext;
      livesReg      <= livesNext;
      levelReg      <= levelNext;
      shiftCountReg <= shiftCountNext;
      holdCountReg  <= holdCountNext;
      carShiftReg   <= carShiftNext;
    end
  end

  always_comb begin
    stateNext      = stateReg;
    livesNext      = livesReg;
    levelNext      = levelReg;
    shiftCountNext = shiftCountReg;
    holdCountNext  = holdCountReg;
    carShiftNext   = 1'b0;
    pointClear     = 1'b1;
    case (stateReg)
      IDLE, GAMEOVER, WIN: begin
        if (startPressed) stateNext = ARM;
      end
      ARM: begin
        pointClear     = 1'b0;
        livesNext      = 2'(LIVES_INIT);
        levelNext      = 3'd0;
        shiftCountNext = '0;
        if (!startPressed) stateNext = PLAY;
      end
      PLAY: begin
        if (tickPulse) begin
          if (32'(shiftCountReg) + 32'd1 >= shiftPeriod) begin
            shiftCountNext = '0;
            carShiftNext   = 1'b1;
          end else begin
            shiftCountNext = shiftCountReg + 1'b1;
          end
        end
        // A collision outranks reaching the goal in the same cycle.
        if (collision) begin
          stateNext = HIT;
          if (livesReg != 2'd0) livesNext = livesReg - 2'd1;
        end else if (goal) begin
          stateNext = LEVELUP;
        end
      end
      HIT: begin
        pointClear    = 1'b0;
        holdCountNext = '0;
        stateNext     = (livesReg == 2'd0) ? GAMEOVER : HOLD;
      end
      HOLD: begin
        if (tickPulse) begin
          if (32'(holdCountReg) + 32'd1 >= 32'(HOLD_TICKS)) begin
            holdCountNext = '0;
            stateNext     = PLAY;
          end else begin
            holdCountNext = holdCountReg + 1'b1;
          end
        end
      end
      LEVELUP: begin
        pointClear     = 1'b0;
        shiftCountNext = '0;
        if (levelReg == 3'(LEVEL_MAX)) begin
          stateNext = WIN;
        end else begin
          levelNext = levelReg + 3'd1;
          stateNext = PLAY;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign gameBus.SC_STATEMACHINEGAME_pointClear_OutLow = pointClear;
  assign gameBus.SC_STATEMACHINEGAME_playing_OutHigh   = (stateReg == PLAY);
  assign gameBus.SC_STATEMACHINEGAME_carShift_OutHigh  = carShiftReg;
  assign gameBus.SC_STATEMACHINEGAME_lives_Out         = livesReg;
  assign gameBus.SC_STATEMACHINEGAME_level_Out         = levelReg;
  assign gameBus.SC_STATEMACHINEGAME_gameOver_OutHigh  = (stateReg == GAMEOVER);
  assign gameBus.SC_STATEMACHINEGAME_win_OutHigh       = (stateReg == WIN);
endmodule
